// File: rtl/layer_serializer_if.sv
// Bus between a layer's parallel outputs and the serial neuron input stream.
interface layer_serializer_if #(
  parameter int unsigned numNeurons = 30,
  parameter int unsigned dataWidth  = 16
) ();

  logic                            in_valid;
  logic [numNeurons*dataWidth-1:0] in_data;
  logic                            out_valid;
  logic [dataWidth-1:0]            out_data;
  logic                            frame_done;
  logic                            busy;
  logic                            overflow;

  // Producer of layer results; observer of the serial stream.
  modport master (
    output in_valid, in_data,
    input  out_valid, out_data, frame_done, busy, overflow
  );

  // Serializer side.
  modport slave (
    input  in_valid, in_data,
    output out_valid, out_data, frame_done, busy, overflow
  );

endinterface

// File: rtl/layer_serializer.sv
// Captures one aligned layer result and replays it one element per cycle,
// with a single pending slot so back-to-back frames stream without a bubble.
module layer_serializer #(
  parameter int unsigned numNeurons = 30,
  parameter int unsigned dataWidth  = 16
) (
  input logic               clk,
  input logic               rst_n,
  layer_serializer_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(numNeurons) + 1;
  localparam int unsigned IDX_W = (numNeurons > 1) ? $clog2(numNeurons) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(numNeurons - 1);
  localparam logic FD_ON_START = (numNeurons == 1);

  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_ACTIVE = 1'b1;

  logic                 r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic [dataWidth-1:0] r_buf [numNeurons];
  logic [dataWidth-1:0] w_buf_nxt [numNeurons];
  logic [dataWidth-1:0] r_pend [numNeurons];
  logic [dataWidth-1:0] w_pend_nxt [numNeurons];
  logic [dataWidth-1:0] w_in_elem [numNeurons];
  logic                 r_pend_valid, w_pend_valid_nxt;
  logic                 r_out_valid, w_out_valid_nxt;
  logic [dataWidth-1:0] r_out_data, w_out_data_nxt;
  logic                 r_frame_done, w_frame_done_nxt;
  logic                 r_overflow, w_overflow_nxt;
  logic                 r_busy, w_busy_nxt;
  logic [CNT_W-1:0]     w_next_cnt;
  logic                 w_last;

  // Split the flat input bus into elements.
  always_comb begin
    for (int i = 0; i < int'(numNeurons); i++) begin
      w_in_elem[i] = bus.in_data[i*dataWidth +: dataWidth];
    end
  end

  assign w_next_cnt = r_cnt + CNT_W'(1);
  assign w_last     = (r_cnt == LAST_CNT);

  // Next-state and output decode.
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_buf_nxt        = r_buf;
    w_pend_nxt       = r_pend;
    w_pend_valid_nxt = r_pend_valid;
    w_out_valid_nxt  = r_out_valid;
    w_out_data_nxt   = r_out_data;
    w_frame_done_nxt = r_frame_done;
    w_overflow_nxt   = r_overflow;

    case (r_state)
      ST_IDLE: begin
        w_out_valid_nxt  = 1'b0;
        w_frame_done_nxt = 1'b0;
        if (bus.in_valid) begin
          w_buf_nxt        = w_in_elem;
          w_out_data_nxt   = w_in_elem[0];
          w_out_valid_nxt  = 1'b1;
          w_frame_done_nxt = FD_ON_START;
          w_cnt_nxt        = '0;
          w_state_nxt      = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (!w_last) begin
          w_out_data_nxt   = r_buf[IDX_W'(w_next_cnt)];
          w_cnt_nxt        = w_next_cnt;
          w_out_valid_nxt  = 1'b1;
          w_frame_done_nxt = (w_next_cnt == LAST_CNT);
          // Mid-frame arrival: park it, or drop it if the slot is taken.
          if (bus.in_valid) begin
            if (!r_pend_valid) begin
              w_pend_nxt       = w_in_elem;
              w_pend_valid_nxt = 1'b1;
            end else begin
              w_overflow_nxt = 1'b1;
            end
          end
        end else if (r_pend_valid) begin
          w_buf_nxt        = r_pend;
          w_out_data_nxt   = r_pend[0];
          w_out_valid_nxt  = 1'b1;
          w_frame_done_nxt = FD_ON_START;
          w_cnt_nxt        = '0;
          w_pend_valid_nxt = bus.in_valid;
          if (bus.in_valid) begin
            w_pend_nxt = w_in_elem;
          end
        end else if (bus.in_valid) begin
          w_buf_nxt        = w_in_elem;
          w_out_data_nxt   = w_in_elem[0];
          w_out_valid_nxt  = 1'b1;
          w_frame_done_nxt = FD_ON_START;
          w_cnt_nxt        = '0;
        end else begin
          w_out_valid_nxt  = 1'b0;
          w_frame_done_nxt = 1'b0;
          w_state_nxt      = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt == ST_ACTIVE) | w_pend_valid_nxt;
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_pend_valid <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_frame_done <= 1'b0;
      r_overflow   <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_pend_valid <= w_pend_valid_nxt;
      r_out_valid  <= w_out_valid_nxt;
      r_out_data   <= w_out_data_nxt;
      r_frame_done <= w_frame_done_nxt;
      r_overflow   <= w_overflow_nxt;
      r_busy       <= w_busy_nxt;
    end
  end

  // Frame storage; contents are qualified by state, so no reset needed.
  always_ff @(posedge clk) begin
    r_buf  <= w_buf_nxt;
    r_pend <= w_pend_nxt;
  end

  assign bus.out_valid  = r_out_valid;
  assign bus.out_data   = r_out_data;
  assign bus.frame_done = r_frame_done;
  assign bus.busy       = r_busy;
  assign bus.overflow   = r_overflow;

endmodule

// File: tb/tb_layer_serializer.sv
// Scoreboard bench for layer_serializer: N=4 and N=1 instances.
module tb_layer_serializer;

  typedef struct packed {
    logic [15:0] d;
    logic        fd;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  exp_t q4[$];
  exp_t q1[$];

  layer_serializer_if #(.numNeurons(4), .dataWidth(16)) if4 ();
  layer_serializer_if #(.numNeurons(1), .dataWidth(16)) if1 ();

  layer_serializer #(.numNeurons(4), .dataWidth(16)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(if4)
  );
  layer_serializer #(.numNeurons(1), .dataWidth(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick4(input logic exp_v);
    tick();
    check("n4_out_valid", 32'(if4.out_valid), 32'(exp_v));
  endtask

  task automatic push4(input logic [15:0] a, b, c, d);
    q4.push_back('{a, 1'b0});
    q4.push_back('{b, 1'b0});
    q4.push_back('{c, 1'b0});
    q4.push_back('{d, 1'b1});
  endtask

  task automatic pulse4(input logic [15:0] a, b, c, d, input logic exp_v);
    if4.in_valid = 1'b1;
    if4.in_data  = {d, c, b, a};
    tick();
    if4.in_valid = 1'b0;
    check("n4_out_valid", 32'(if4.out_valid), 32'(exp_v));
  endtask

  // Monitor: pop and compare whenever the N=4 stream presents an element.
  always @(negedge clk) begin
    if (if4.out_valid) begin
      if (q4.size() == 0) begin
        check("n4_unexpected_elem", 32'(if4.out_data), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = q4.pop_front();
        check("n4_out_data", 32'(if4.out_data), 32'(e.d));
        check("n4_frame_done", 32'(if4.frame_done), 32'(e.fd));
      end
    end
  end

  // Monitor for the N=1 stream.
  always @(negedge clk) begin
    if (if1.out_valid) begin
      if (q1.size() == 0) begin
        check("n1_unexpected_elem", 32'(if1.out_data), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = q1.pop_front();
        check("n1_out_data", 32'(if1.out_data), 32'(e.d));
        check("n1_frame_done", 32'(if1.frame_done), 32'(e.fd));
      end
    end
  end

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    rst_n        = 1'b0;
    if4.in_valid = 1'b0;
    if4.in_data  = '0;
    if1.in_valid = 1'b0;
    if1.in_data  = '0;
    tick();
    tick();
    check("rst_out_valid", 32'(if4.out_valid), 0);
    check("rst_out_data", 32'(if4.out_data), 0);
    check("rst_frame_done", 32'(if4.frame_done), 0);
    check("rst_busy", 32'(if4.busy), 0);
    check("rst_overflow", 32'(if4.overflow), 0);
    rst_n = 1'b1;
    tick();

    // Single frame: 4 valid cycles, busy drops right after the last.
    push4(16'h0001, 16'h0002, 16'h0003, 16'h0004);
    pulse4(16'h0001, 16'h0002, 16'h0003, 16'h0004, 1'b1);
    check("t1_busy_first", 32'(if4.busy), 1);
    for (int i = 0; i < 3; i++) tick4(1'b1);
    check("t1_busy_last", 32'(if4.busy), 1);
    tick4(1'b0);
    check("t1_busy_after", 32'(if4.busy), 0);
    tick();

    // Second frame parked while element 1 is shown: 8 gapless cycles.
    push4(16'h0001, 16'h0002, 16'h0003, 16'h0004);
    push4(16'h000A, 16'h000B, 16'h000C, 16'h000D);
    pulse4(16'h0001, 16'h0002, 16'h0003, 16'h0004, 1'b1);
    tick4(1'b1);
    pulse4(16'h000A, 16'h000B, 16'h000C, 16'h000D, 1'b1);
    for (int i = 0; i < 5; i++) tick4(1'b1);
    check("t2_busy_end", 32'(if4.busy), 1);
    tick4(1'b0);
    check("t2_overflow", 32'(if4.overflow), 0);
    check("t2_busy_after", 32'(if4.busy), 0);
    tick();

    // Third frame while the pending slot is full is dropped.
    push4(16'h0101, 16'h0102, 16'h0103, 16'h0104);
    push4(16'h0201, 16'h0202, 16'h0203, 16'h0204);
    pulse4(16'h0101, 16'h0102, 16'h0103, 16'h0104, 1'b1);
    pulse4(16'h0201, 16'h0202, 16'h0203, 16'h0204, 1'b1);
    pulse4(16'h0301, 16'h0302, 16'h0303, 16'h0304, 1'b1);
    check("t3_overflow_set", 32'(if4.overflow), 1);
    for (int i = 0; i < 5; i++) tick4(1'b1);
    tick4(1'b0);
    tick();
    check("t3_overflow_sticky", 32'(if4.overflow), 1);
    check("t3_busy_after", 32'(if4.busy), 0);

    // New frame on the edge where the last element is shown: no bubble.
    push4(16'h1111, 16'h2222, 16'h3333, 16'h4444);
    push4(16'h5555, 16'h6666, 16'h7777, 16'h8888);
    pulse4(16'h1111, 16'h2222, 16'h3333, 16'h4444, 1'b1);
    for (int i = 0; i < 3; i++) tick4(1'b1);
    pulse4(16'h5555, 16'h6666, 16'h7777, 16'h8888, 1'b1);
    for (int i = 0; i < 3; i++) tick4(1'b1);
    tick4(1'b0);
    tick();

    // Reset while element 2 is shown aborts the frame.
    push4(16'h0011, 16'h0022, 16'h0033, 16'h0044);
    pulse4(16'h0011, 16'h0022, 16'h0033, 16'h0044, 1'b1);
    tick4(1'b1);
    tick4(1'b1);
    check("t5_elem2_shown", 32'(if4.out_data), 32'h33);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    q4.delete();
    check("t5_rst_out_valid", 32'(if4.out_valid), 0);
    check("t5_rst_out_data", 32'(if4.out_data), 0);
    check("t5_rst_busy", 32'(if4.busy), 0);
    check("t5_rst_overflow", 32'(if4.overflow), 0);
    tick4(1'b0);
    push4(16'h0005, 16'h0006, 16'h0007, 16'h0008);
    pulse4(16'h0005, 16'h0006, 16'h0007, 16'h0008, 1'b1);
    for (int i = 0; i < 3; i++) tick4(1'b1);
    tick4(1'b0);
    tick();

    // N=1: two consecutive pulses give two elements, each a whole frame.
    q1.push_back('{16'h1234, 1'b1});
    q1.push_back('{16'h5678, 1'b1});
    if1.in_valid = 1'b1;
    if1.in_data  = 16'h1234;
    tick();
    check("n1_valid_0", 32'(if1.out_valid), 1);
    if1.in_data  = 16'h5678;
    tick();
    if1.in_valid = 1'b0;
    check("n1_valid_1", 32'(if1.out_valid), 1);
    check("n1_busy_1", 32'(if1.busy), 1);
    tick();
    check("n1_valid_2", 32'(if1.out_valid), 0);
    check("n1_busy_2", 32'(if1.busy), 0);
    tick();
    tick();

    check("n4_queue_drained", 32'(q4.size()), 0);
    check("n1_queue_drained", 32'(q1.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/layer_serializer.md
Name: layer_serializer

Overview:
- Producer side of the per-neuron serial input stream (`neuron_in_valid` / `neuron_in`).
- Captures the parallel outputs of one layer, which arrive as a single aligned valid pulse across all neurons, and replays them as one value per cycle to the next layer's neurons.
- One pending slot absorbs a second layer result that arrives while a frame is still streaming. Back-to-back frames are emitted with no bubble.

Parameters:
- numNeurons, 30, number of neuron outputs per frame (≥1); equals the next layer's weightSize.
- dataWidth, 16, width of each neuron value.
- cntWidth, $clog2(numNeurons)+1, element index counter width (derived).

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset; synchronous, active-low.
- in_valid  input  1  one-cycle pulse: in_data holds a complete layer result.
- in_data  input  numNeurons*dataWidth  element i = in_data[i*dataWidth +: dataWidth].
- out_valid  output  1  drives next-layer neuron_in_valid.
- out_data  output  dataWidth  drives next-layer neuron_in.
- frame_done  output  1  high with the last element of each frame.
- busy  output  1  active | pend_valid.
- overflow  output  1  sticky: a frame was dropped.

Behaviour:
- All outputs are registered. Internal state: buf (numNeurons×dataWidth), pend (same), pend_valid, active, cnt = index of the element currently on out_data.
- Reset (rst_n=0 at a clk edge) clears out_valid, out_data, frame_done, overflow, active, pend_valid and cnt to 0. Reset mid-frame aborts the frame; the remaining elements are never emitted.
- IDLE (active=0), in_valid=1 at edge k:
  - buf <= in_data; out_data <= element0; out_valid <= 1; cnt <= 0; active <= 1.
  - Latency is 1 cycle: element0 is visible after edge k.
  - If numNeurons=1, frame_done <= 1 at the same edge.
- IDLE, in_valid=0: out_valid=0, frame_done=0, out_data holds its last value.
- ACTIVE, cnt < numNeurons-1: out_data <= buf[cnt+1]; cnt++; out_valid stays 1.
  - frame_done <= 1 when cnt+1 = numNeurons-1, else 0.
- ACTIVE, cnt = numNeurons-1 (last element currently displayed), decided in priority order:
  - pend_valid=1: buf <= pend, emit element0, cnt <= 0. pend_valid <= in_valid; if in_valid, pend <= in_data.
  - else if in_valid: buf <= in_data, emit element0, cnt <= 0 (gapless).
  - else: out_valid <= 0, frame_done <= 0, active <= 0.
- in_valid while ACTIVE and cnt < numNeurons-1:
  - pend_valid=0: pend <= in_data, pend_valid <= 1.
  - pend_valid=1: the new frame is dropped, overflow <= 1, pend is unchanged.
- A frame always occupies exactly numNeurons consecutive out_valid cycles; there are no gaps inside a frame.
- Element order is ascending index (0 first).
- No arithmetic is performed; values pass through bit-exact.
- overflow is cleared only by reset.
- busy is registered consistently with active/pend_valid: it is high from the edge after capture until the last element of the final queued frame has been emitted.

Test Plan:
- N=4, W=16, single in_valid with elements {0x0001,0x0002,0x0003,0x0004}:
  - out_valid high for exactly 4 cycles starting 1 cycle after the pulse.
  - out_data 1,2,3,4 in order; frame_done high only on the 0x0004 cycle.
  - busy drops the cycle after that.
- Second in_valid {0xA,0xB,0xC,0xD} while element 1 is displayed:
  - 8 consecutive out_valid cycles, 1,2,3,4,A,B,C,D.
  - frame_done on 4 and D; overflow=0.
- Third in_valid arrives while pend_valid=1 and cnt<3: that frame never appears; overflow=1 and stays 1 after the stream ends.
- in_valid on the same edge where element 4 (last) is displayed and pend empty: next cycle shows element0 of the new frame; out_valid never drops.
- rst_n low for 1 cycle while element 2 is displayed:
  - next cycle out_valid=0, out_data=0, busy=0, overflow=0.
  - A later in_valid {5,6,7,8} streams normally.
- N=1 variant, two in_valid pulses 1 cycle apart (0x1234, 0x5678): out_valid high 2 cycles, out_data 0x1234 then 0x5678, frame_done high both cycles.
